// File: rtl/ps2_key_state_decoder.sv
// ps2_key_state_decoder
//   Turns PS/2 set-2 scan bytes into a per-key "held" bitmap. Make codes
//   set a key bit and fire press_pulse. Break codes (F0 prefix) clear it
//   and fire release_pulse. A held key that sends its make code again
//   (typematic repeat) is ignored. AA (keyboard self-test) clears every key.
//   A prefix that is not followed by a byte within TIMEOUT_CYCLES is dropped
//   and flagged with seq_error.
//
// Optional feature macro: PS2_EXTENDED_KEYS_EN
//   When defined, E0-prefixed codes are decoded (states EXT/EXT_BRK,
//   table indices 30..33).
//   When undefined, E0 is discarded in IDLE and bits 30..33 stay 0.
//
// Ports
//   CLOCK_50      in   system clock, rising edge only
//   resetn        in   synchronous active-low reset
//   rx_data[7:0]  in   byte from the PS/2 receiver
//   rx_valid      in   one-cycle strobe qualifying rx_data
//   key_state     out  NUM_KEYS level bitmap, 1 = held
//   press_pulse   out  one-cycle strobe on a new press
//   release_pulse out  one-cycle strobe on a release
//   key_index     out  table index behind the most recent pulse
//   held_count    out  popcount of key_state
//   seq_error     out  one-cycle strobe when a prefix times out
module ps2_key_state_decoder #(
  parameter int NUM_KEYS       = 34,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic [5:0]          key_index,
  output logic [6:0]          held_count,
  output logic                seq_error
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef PS2_EXTENDED_KEYS_EN
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BRK     = 2'd1,
    EXT     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BRK  = 1'b1
  } state_t;
`endif

  // Result format of the lookups: {hit, index[5:0]}
  function automatic logic [6:0] lookup_base(input logic [7:0] code);
    logic [6:0] r;
    case (code)
      8'h0E: r = {1'b1, 6'd0};
      8'h16: r = {1'b1, 6'd1};
      8'h1E: r = {1'b1, 6'd2};
      8'h26: r = {1'b1, 6'd3};
      8'h25: r = {1'b1, 6'd4};
      8'h2E: r = {1'b1, 6'd5};
      8'h36: r = {1'b1, 6'd6};
      8'h3D: r = {1'b1, 6'd7};
      8'h3E: r = {1'b1, 6'd8};
      8'h46: r = {1'b1, 6'd9};
      8'h45: r = {1'b1, 6'd10};
      8'h4E: r = {1'b1, 6'd11};
      8'h55: r = {1'b1, 6'd12};
      8'h66: r = {1'b1, 6'd13};
      8'h0D: r = {1'b1, 6'd14};
      8'h15: r = {1'b1, 6'd15};
      8'h1D: r = {1'b1, 6'd16};
      8'h24: r = {1'b1, 6'd17};
      8'h2D: r = {1'b1, 6'd18};
      8'h2C: r = {1'b1, 6'd19};
      8'h35: r = {1'b1, 6'd20};
      8'h3C: r = {1'b1, 6'd21};
      8'h43: r = {1'b1, 6'd22};
      8'h44: r = {1'b1, 6'd23};
      8'h4D: r = {1'b1, 6'd24};
      8'h54: r = {1'b1, 6'd25};
      8'h5B: r = {1'b1, 6'd26};
      8'h5D: r = {1'b1, 6'd27};
      8'h29: r = {1'b1, 6'd28};
      8'h5A: r = {1'b1, 6'd29};
      default: r = 7'd0;
    endcase
    return r;
  endfunction

`ifdef PS2_EXTENDED_KEYS_EN
  function automatic logic [6:0] lookup_ext(input logic [7:0] code);
    logic [6:0] r;
    case (code)
      8'h75: r = {1'b1, 6'd30};
      8'h72: r = {1'b1, 6'd31};
      8'h6B: r = {1'b1, 6'd32};
      8'h74: r = {1'b1, 6'd33};
      default: r = 7'd0;
    endcase
    return r;
  endfunction
`endif

  state_t              state_r, state_nxt;
  logic [NUM_KEYS-1:0] key_state_r, key_state_nxt;
  logic                press_r, press_nxt;
  logic                release_r, release_nxt;
  logic [5:0]          key_index_r, key_index_nxt;
  logic [6:0]          held_r, held_nxt;
  logic                seq_err_r, seq_err_nxt;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt;

  logic [6:0]          lookup_s;
  logic [5:0]          idx_s;
  logic                hit_s;
  logic                do_make_s;
  logic                do_break_s;

  // Table lookup selected by whether the current byte follows an E0 prefix
  always_comb begin
`ifdef PS2_EXTENDED_KEYS_EN
    if ((state_r == EXT) || (state_r == EXT_BRK)) begin
      lookup_s = lookup_ext(rx_data);
    end else begin
      lookup_s = lookup_base(rx_data);
    end
`else
    lookup_s = lookup_base(rx_data);
`endif
    idx_s = lookup_s[5:0];
    // Indices beyond the configured bitmap are treated as unmapped
    hit_s = lookup_s[6] && (int'(idx_s) < NUM_KEYS);
  end

  // Next-state, key bitmap, pulse and timeout logic
  always_comb begin
    state_nxt     = state_r;
    key_state_nxt = key_state_r;
    press_nxt     = 1'b0;
    release_nxt   = 1'b0;
    key_index_nxt = key_index_r;
    held_nxt      = held_r;
    seq_err_nxt   = 1'b0;
    cnt_nxt       = cnt_r;
    do_make_s     = 1'b0;
    do_break_s    = 1'b0;

    if (rx_valid) begin
      // A byte always wins over a same-cycle timeout expiry
      cnt_nxt   = '0;
      state_nxt = IDLE;
      case (state_r)
        IDLE: begin
          if (rx_data == 8'hF0) begin
            state_nxt = BRK;
          end else if (rx_data == 8'hE0) begin
`ifdef PS2_EXTENDED_KEYS_EN
            state_nxt = EXT;
`else
            state_nxt = IDLE;
`endif
          end else if (rx_data == 8'hAA) begin
            key_state_nxt = '0;
            held_nxt      = 7'd0;
          end else begin
            do_make_s = 1'b1;
          end
        end
        BRK: begin
          do_break_s = 1'b1;
        end
`ifdef PS2_EXTENDED_KEYS_EN
        EXT: begin
          if (rx_data == 8'hF0) begin
            state_nxt = EXT_BRK;
          end else begin
            do_make_s = 1'b1;
          end
        end
        EXT_BRK: begin
          do_break_s = 1'b1;
        end
`endif
        default: begin
          state_nxt = IDLE;
        end
      endcase

      // Repeats of a held key and breaks of an idle key fall through silently
      if (do_make_s && hit_s && !key_state_r[idx_s]) begin
        key_state_nxt[idx_s] = 1'b1;
        press_nxt            = 1'b1;
        key_index_nxt        = idx_s;
        held_nxt             = held_r + 7'd1;
      end else if (do_break_s && hit_s && key_state_r[idx_s]) begin
        key_state_nxt[idx_s] = 1'b0;
        release_nxt          = 1'b1;
        key_index_nxt        = idx_s;
        held_nxt             = held_r - 7'd1;
      end else begin
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
      end
    end else if (state_r != IDLE) begin
      if (cnt_r == CNT_LAST) begin
        state_nxt   = IDLE;
        seq_err_nxt = 1'b1;
        cnt_nxt     = '0;
      end else begin
        cnt_nxt = cnt_r + CNT_ONE;
      end
    end else begin
      cnt_nxt = '0;
    end
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state_r     <= IDLE;
      key_state_r <= '0;
      press_r     <= 1'b0;
      release_r   <= 1'b0;
      key_index_r <= 6'd0;
      held_r      <= 7'd0;
      seq_err_r   <= 1'b0;
      cnt_r       <= '0;
    end else begin
      state_r     <= state_nxt;
      key_state_r <= key_state_nxt;
      press_r     <= press_nxt;
      release_r   <= release_nxt;
      key_index_r <= key_index_nxt;
      held_r      <= held_nxt;
      seq_err_r   <= seq_err_nxt;
      cnt_r       <= cnt_nxt;
    end
  end

  assign key_state     = key_state_r;
  assign press_pulse   = press_r;
  assign release_pulse = release_r;
  assign key_index     = key_index_r;
  assign held_count    = held_r;
  assign seq_error     = seq_err_r;

endmodule

// File: doc/ps2_key_state_decoder.md
PS2_KEY_STATE_DECODER -- requirements
Module: ps2_key_state_decoder

Interface
REQ-001 Parameter NUM_KEYS, default 34, number of tracked keys (legal 1..34); table indices >= NUM_KEYS SHALL be ignored.
REQ-002 Parameter TIMEOUT_CYCLES, default 1_000_000, maximum CLOCK_50 cycles allowed between a prefix byte and its following byte.
REQ-003 CLOCK_50  in  1  system clock; all logic SHALL be clocked on its rising edge only.
REQ-004 resetn  in  1  synchronous active-low reset.
REQ-005 rx_data  in  8  byte received from the PS2 controller.
REQ-006 rx_valid  in  1  one-cycle strobe; rx_data is valid while it is high.
REQ-007 key_state  out  NUM_KEYS  level per key, 1 = held.
REQ-008 press_pulse  out  1  one-cycle strobe for a new key press.
REQ-009 release_pulse  out  1  one-cycle strobe for a key release.
REQ-010 key_index  out  6  table index of the key behind the last pulse.
REQ-011 held_count  out  7  number of bits currently set in key_state.
REQ-012 seq_error  out  1  one-cycle strobe when a prefix times out.

Function
REQ-013 Key table (index:code) SHALL be 0:0E 1:16 2:1E 3:26 4:25 5:2E 6:36 7:3D 8:3E 9:46 10:45 11:4E 12:55 13:66 14:0D 15:15 16:1D 17:24 18:2D 19:2C 20:35 21:3C 22:43 23:44 24:4D 25:54 26:5B 27:5D 28:29 29:5A, then extended 30:E0-75 31:E0-72 32:E0-6B 33:E0-74.
REQ-014 FSM states SHALL be IDLE, BRK (after F0), EXT (after E0) and EXT_BRK (after E0 F0).
REQ-015 Transitions: IDLE+F0->BRK, IDLE+E0->EXT, EXT+F0->EXT_BRK; any other byte in any state SHALL be decoded and return the FSM to IDLE.
REQ-016 Make code (IDLE/EXT) mapping to bit k that is 0: set bit k, press_pulse=1, key_index=k on the edge after the rx_valid cycle (latency 1).
REQ-017 Make code for bit k that is already 1 (typematic repeat): no pulse, no state change.
REQ-018 Break code (BRK/EXT_BRK) for bit k that is 1: clear bit k, release_pulse=1, key_index=k, latency 1; if bit k is 0, no pulse.
REQ-019 Unmapped codes SHALL cause no pulse and no key_state change; FA and FE SHALL be ignored in IDLE.
REQ-020 Byte AA received in IDLE (keyboard self-test) SHALL clear all of key_state and hold held_count at 0, with no pulses.
REQ-021 held_count SHALL be incremented on press_pulse and decremented on release_pulse, and SHALL always equal popcount(key_state).
REQ-022 Timeout counter SHALL run only in BRK/EXT/EXT_BRK; reaching TIMEOUT_CYCLES SHALL force IDLE and pulse seq_error once.
REQ-023 When rx_valid and timeout expiry occur in the same cycle, the byte SHALL be processed and seq_error SHALL NOT assert.
REQ-024 press_pulse and release_pulse SHALL never both be high; key_index SHALL hold its value between pulses.

Reset
REQ-025 resetn low at an edge: FSM->IDLE; key_state, held_count, key_index and timeout counter = 0; all pulses = 0.
REQ-026 Reset asserted mid-sequence (e.g. after F0) SHALL discard the pending prefix; the first byte after reset SHALL be decoded from IDLE.

Configuration
REQ-027 Macro PS2_EXTENDED_KEYS_EN defined: E0 prefix handling, states EXT/EXT_BRK and indices 30-33 are active.
REQ-028 Macro PS2_EXTENDED_KEYS_EN undefined: E0 SHALL be discarded in IDLE with the FSM staying in IDLE; no EXT states exist; bits 30-33 SHALL read 0.

Verification
REQ-029 Reset, rx 1C (A not in table -> none), rx 15 -> key_state[15]=1, press_pulse one cycle, key_index=15, held_count=1.
REQ-030 rx 15 ×3 while held -> exactly one press_pulse total; then rx F0,15 -> release_pulse, key_state[15]=0, held_count=0.
REQ-031 With PS2_EXTENDED_KEYS_EN: rx E0,75 -> bit 30 set; rx E0,F0,75 -> bit 30 cleared and release_pulse with key_index=30; without the macro, same stimulus -> bit 30 stays 0.
REQ-032 Press 29 and 16, then rx F0 and no byte for TIMEOUT_CYCLES -> seq_error pulse, FSM IDLE; a following rx 16 SHALL be treated as a repeat with no pulse.
REQ-033 Hold keys 28 and 5, rx AA -> key_state=0, held_count=0, no pulses.
REQ-034 rx F0, then resetn low for one cycle, then rx 1E -> press_pulse with key_index=2 (not a release).
